instr_encoder: RTL
==================

# instr_encoder

Instruction encoder and program loader for the 16-bit CPU. It is the inverse of the instruction decoder. It accepts decoded fields (opcode, regid, immed) over a valid/ready handshake and packs them into 16-bit instruction words. Words are buffered in a small FIFO and written sequentially into instruction memory starting at a base address. It sits between the boot/debug loader path and the instruction memory write port.

## Interface

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, at least 2.
- BASE_ADDR, 0, first memory address written after start.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE).
- finish  input  1  one-cycle pulse; marks end of program (honoured only in LOAD).
- in_valid  input  1  field triple valid.
- in_ready  output  1  encoder accepts the triple this cycle.
- opcode  input  6  instruction opcode.
- regid  input  1  register select.
- immed  input  9  immediate.
- mem_we  output  1  write request to instruction memory.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  16  encoded instruction word.
- busy  output  1  high in LOAD or FLUSH.
- done  output  1  one-cycle pulse at session end.
- overflow  output  1  sticky; last memory address was written with input still pending.
- word_count  output  ADDR_WIDTH+1  words written this session.

## Operation

- Encoding: word = {opcode, regid, immed}. Bits [15:10] hold the opcode, bit [9] holds regid, bits [8:0] hold immed. This is bit-exact with the decoder field split.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: on start, clear word_count and overflow, set mem_addr to BASE_ADDR, go to LOAD.
  - LOAD: accept triples and drain the FIFO. On finish, go to FLUSH.
  - FLUSH: in_ready is 0. Keep draining. When the FIFO is empty, go to DONE.
  - DONE: pulse done for 1 cycle, go to IDLE.
- in_ready = (state==LOAD) && !fifo_full && !overflow.
- Accept occurs when in_valid && in_ready. The encoded word is pushed to the FIFO at that edge.
- mem_we = (state is LOAD or FLUSH) && fifo not empty.
- mem_wdata comes from the FIFO head (registered storage).
- A write completes when mem_we && mem_ready. At that edge:
  - pop the FIFO;
  - increment word_count;
  - increment mem_addr.
- mem_we, mem_addr and mem_wdata hold stable while mem_ready is low.
- Push and pop in the same cycle are allowed when the FIFO is non-full and non-empty; occupancy is unchanged.
- Wrap-around: a completed write at address 2^ADDR_WIDTH-1 is the last write of the session. mem_addr holds at its maximum; it never wraps.
  - If input is still pending (FIFO not empty after the pop, or in_valid high in LOAD), set overflow to 1. Remaining FIFO entries are discarded.
  - The FSM goes to DONE in either case.
- start outside IDLE and finish outside LOAD are ignored.
- finish together with an accepted triple: the triple is kept, then the FSM goes to FLUSH.
- rst at any time:
  - FSM returns to IDLE;
  - FIFO is emptied;
  - any in-progress write is abandoned (mem_we drops asynchronously).

## Timing

- Reset values:
  - in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0;
  - busy 0, done 0, overflow 0, word_count 0;
  - FIFO storage 0.
- start at edge N: LOAD at N+1. in_ready can be high from cycle N+1.
- Latency from an accept at edge N to mem_we high is cycle N+1 (FIFO previously empty). The earliest completed write is at edge N+1.
- Throughput: with mem_ready held high, 1 word per cycle sustained.
- done is high exactly 1 cycle, the cycle after the FSM enters DONE. busy is low in that cycle.
- overflow sets at the edge of the final write and holds until the next start or rst.

## Test plan

- Reset, then start, then one triple opcode=6'b100000, regid=0, immed=9'd1, then finish, with mem_ready=1 -> exactly one write: addr 0, data 16'h8001. word_count=1. done pulses once.
- Stream 8 triples back-to-back, opcode=i, regid=i[0], immed=i*3, with mem_ready=1 -> 8 writes at addresses 0..7, data {i,i[0],i*3}. in_ready never drops. word_count=8.
- Hold mem_ready=0 while streaming -> exactly FIFO_DEPTH (4) triples are accepted, then in_ready=0 and mem_wdata is stable. Release mem_ready -> all 4 words are written in order. Input resumes.
- ADDR_WIDTH=3, 10 triples -> writes land at 0..7 only. overflow=1, mem_addr stays 7, done pulses, word_count=8.
- Assert rst mid-stream with 2 words buffered and mem_we high -> all outputs go to reset values immediately. No further writes. A subsequent start writes from BASE_ADDR.
- start pulse while in LOAD, and finish while in IDLE -> no state change. The session continues unaffected.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields {opcode, regid, immed} into
// 16-bit words, buffers them in a small FIFO and writes them sequentially into
// instruction memory starting at BASE_ADDR.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, finish       session control pulses (start in IDLE, finish in LOAD)
//   in_valid/in_ready   field-triple handshake; opcode[5:0], regid, immed[8:0]
//   mem_we/mem_ready    memory write handshake; mem_addr, mem_wdata
//   busy                high in LOAD or FLUSH
//   done                one-cycle pulse while in DONE
//   overflow            sticky: last address written with input still pending
//   word_count          words written this session
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic                  regid,
  input  logic [8:0]            immed,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [PTR_W:0]        CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           fifo_q [FIFO_DEPTH];
  logic [15:0]           fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic                  ovf_q, ovf_d;

  logic fifo_empty, fifo_full, draining, push, pop, last_write, pending;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign draining   = (state_q == S_LOAD) || (state_q == S_FLUSH);

  assign in_ready   = (state_q == S_LOAD) && !fifo_full && !ovf_q;
  assign push       = in_valid && in_ready;
  assign mem_we     = draining && !fifo_empty;
  assign pop        = mem_we && mem_ready;
  // A write at the top address ends the session; the address never wraps.
  assign last_write = pop && (addr_q == ADDR_MAX);
  // Anything left behind by that final write counts as lost input.
  assign pending    = (count_q > (PTR_W+1)'(1)) || ((state_q == S_LOAD) && in_valid);

  assign mem_addr   = addr_q;
  assign mem_wdata  = fifo_q[rd_ptr_q];
  assign busy       = draining;
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign word_count = wc_q;

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    wc_d     = wc_q;
    ovf_d    = ovf_q;

    if (push) begin
      fifo_d[wr_ptr_q] = {opcode, regid, immed};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wc_d     = wc_q + (ADDR_WIDTH+1)'(1);
      if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_WIDTH'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = '0;
          ovf_d   = 1'b0;
          addr_d  = ADDR_BASE;
        end
      end
      S_LOAD: begin
        if (last_write)  state_d = S_DONE;
        else if (finish) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (last_write || fifo_empty) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Session is over: drop whatever is still buffered (including a push
    // accepted in the same cycle).
    if (last_write) begin
      ovf_d    = ovf_q | pending;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= ADDR_BASE;
      wc_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wc_q     <= wc_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
